// File: rtl/easyaxi_pkg.sv
// EasyAXI shared widths and encodings.
// Also provides the master-index width helper and the arbiter FSM state type.
package easyaxi_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;
  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  localparam int OS_CNT_W = 3;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    AR_IDLE,
    AR_GRANT
  } ar_state_e;

endpackage

// File: rtl/easyaxi_rd_arb_if.sv
// Upstream master AR/R bundle plus the shared downstream AR/R port.
// The slave modport is the arbiter's view, master the environment's.
interface easyaxi_rd_arb_if
  import easyaxi_pkg::*;
#(
  parameter int NUM_MST = 2,
  parameter int IDX_W   = 1
) ();

  logic [NUM_MST-1:0]             mst_arvalid;
  logic [NUM_MST-1:0]             mst_arready;
  logic [NUM_MST*AXI_ID_W-1:0]    mst_arid;
  logic [NUM_MST*AXI_ADDR_W-1:0]  mst_araddr;
  logic [NUM_MST*AXI_LEN_W-1:0]   mst_arlen;
  logic [NUM_MST*AXI_SIZE_W-1:0]  mst_arsize;
  logic [NUM_MST*AXI_BURST_W-1:0] mst_arburst;
  logic [NUM_MST-1:0]             mst_rvalid;
  logic [NUM_MST-1:0]             mst_rready;
  logic [AXI_ID_W-1:0]            mst_rid;
  logic [AXI_DATA_W-1:0]          mst_rdata;
  logic [AXI_RESP_W-1:0]          mst_rresp;
  logic                           mst_rlast;

  logic                           slv_arvalid;
  logic                           slv_arready;
  logic [AXI_ID_W+IDX_W-1:0]      slv_arid;
  logic [AXI_ADDR_W-1:0]          slv_araddr;
  logic [AXI_LEN_W-1:0]           slv_arlen;
  logic [AXI_SIZE_W-1:0]          slv_arsize;
  logic [AXI_BURST_W-1:0]         slv_arburst;
  logic                           slv_rvalid;
  logic                           slv_rready;
  logic [AXI_ID_W+IDX_W-1:0]      slv_rid;
  logic [AXI_DATA_W-1:0]          slv_rdata;
  logic [AXI_RESP_W-1:0]          slv_rresp;
  logic                           slv_rlast;

  modport slave (
    input  mst_arvalid, mst_arid, mst_araddr, mst_arlen,
    input  mst_arsize, mst_arburst, mst_rready,
    output mst_arready, mst_rvalid, mst_rid, mst_rdata,
    output mst_rresp, mst_rlast,
    output slv_arvalid, slv_arid, slv_araddr, slv_arlen,
    output slv_arsize, slv_arburst, slv_rready,
    input  slv_arready, slv_rvalid, slv_rid, slv_rdata,
    input  slv_rresp, slv_rlast
  );

  modport master (
    output mst_arvalid, mst_arid, mst_araddr, mst_arlen,
    output mst_arsize, mst_arburst, mst_rready,
    input  mst_arready, mst_rvalid, mst_rid, mst_rdata,
    input  mst_rresp, mst_rlast,
    input  slv_arvalid, slv_arid, slv_araddr, slv_arlen,
    input  slv_arsize, slv_arburst, slv_rready,
    output slv_arready, slv_rvalid, slv_rid, slv_rdata,
    output slv_rresp, slv_rlast
  );

endinterface

// File: rtl/easyaxi_rr_sel.sv
// Round-robin first-eligible finder: lowest offset upward from ptr_i,
// wrapping modulo N, returned as one-hot and index.
module easyaxi_rr_sel #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_oh_o,
  output logic [W-1:0] gnt_idx_o
);

  always_comb begin
    int best;
    int off;
    best      = N;
    off       = 0;
    gnt_idx_o = '0;
    gnt_oh_o  = '0;
    for (int j = 0; j < N; j++) begin
      off = (j >= int'(ptr_i)) ? j - int'(ptr_i)
                               : j + N - int'(ptr_i);
      if (req_i[j] && off < best) begin
        best      = off;
        gnt_idx_o = W'(j);
      end
    end
    for (int j = 0; j < N; j++)
      gnt_oh_o[j] = (best < N) && (gnt_idx_o == W'(j));
  end

endmodule

// File: rtl/easyaxi_rd_arb.sv
// N:1 EasyAXI read arbiter: round-robin AR grant with per-master
// outstanding limit, ARID prefixing and R routing by prefix.
module easyaxi_rd_arb
  import easyaxi_pkg::*;
#(
  parameter int NUM_MST = 2,
  parameter int IDX_W   = idx_w(NUM_MST),
  parameter int MAX_OS  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  easyaxi_rd_arb_if.slave bus,
  output logic            dec_err
);

  localparam int SID_W = AXI_ID_W + IDX_W;
  localparam logic [OS_CNT_W-1:0] OS_MAX = OS_CNT_W'(MAX_OS);

  ar_state_e           state_q, state_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OS_CNT_W-1:0] os_cnt_q [NUM_MST];
  logic [OS_CNT_W-1:0] os_cnt_d [NUM_MST];
  logic                dec_err_q, dec_err_d;

  logic [NUM_MST-1:0]  elig;
  logic [NUM_MST-1:0]  sel_oh;
  logic [IDX_W-1:0]    sel_idx;
  logic [NUM_MST-1:0]  r_last_hs;
  logic [IDX_W-1:0]    r_idx;
  logic                r_idx_ok;
  logic                ar_hs;

  always_comb begin
    for (int i = 0; i < NUM_MST; i++)
      elig[i] = bus.mst_arvalid[i] && (os_cnt_q[i] < OS_MAX);
  end

  easyaxi_rr_sel #(
    .N (NUM_MST),
    .W (IDX_W)
  ) u_sel (
    .req_i     (elig),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (sel_oh),
    .gnt_idx_o (sel_idx)
  );

  // Payload follows gnt_q in both states; valid/ready only in GRANT.
  always_comb begin
    bus.slv_arvalid = 1'b0;
    bus.mst_arready = '0;
    bus.slv_arid    = '0;
    bus.slv_araddr  = '0;
    bus.slv_arlen   = '0;
    bus.slv_arsize  = '0;
    bus.slv_arburst = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (gnt_q == IDX_W'(i)) begin
        bus.slv_arid    = {gnt_q, bus.mst_arid[i*AXI_ID_W +: AXI_ID_W]};
        bus.slv_araddr  = bus.mst_araddr[i*AXI_ADDR_W +: AXI_ADDR_W];
        bus.slv_arlen   = bus.mst_arlen[i*AXI_LEN_W +: AXI_LEN_W];
        bus.slv_arsize  = bus.mst_arsize[i*AXI_SIZE_W +: AXI_SIZE_W];
        bus.slv_arburst = bus.mst_arburst[i*AXI_BURST_W +: AXI_BURST_W];
        if (state_q == AR_GRANT) begin
          bus.slv_arvalid    = bus.mst_arvalid[i];
          bus.mst_arready[i] = bus.slv_arready;
        end
      end
    end
  end

  assign ar_hs = bus.slv_arvalid && bus.slv_arready;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      AR_IDLE: begin
        if (|sel_oh) begin
          state_d = AR_GRANT;
          gnt_d   = sel_idx;
        end
      end
      AR_GRANT: begin
        if (ar_hs) begin
          state_d  = AR_IDLE;
          rr_ptr_d = (gnt_q == IDX_W'(NUM_MST - 1)) ? '0 : gnt_q + 1'b1;
        end
      end
    endcase
  end

  assign r_idx    = bus.slv_rid[SID_W-1 -: IDX_W];
  assign r_idx_ok = 32'(r_idx) < 32'(NUM_MST);

  // Out-of-range prefixes are sunk with slv_rready held high.
  always_comb begin
    bus.mst_rvalid = '0;
    bus.slv_rready = 1'b1;
    r_last_hs      = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (r_idx_ok && r_idx == IDX_W'(i)) begin
        bus.mst_rvalid[i] = bus.slv_rvalid;
        bus.slv_rready    = bus.mst_rready[i];
        r_last_hs[i]      = bus.slv_rvalid && bus.mst_rready[i]
                            && bus.slv_rlast;
      end
    end
  end

  assign bus.mst_rid   = bus.slv_rid[AXI_ID_W-1:0];
  assign bus.mst_rdata = bus.slv_rdata;
  assign bus.mst_rresp = bus.slv_rresp;
  assign bus.mst_rlast = bus.slv_rlast;

  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      logic inc;
      inc         = ar_hs && (gnt_q == IDX_W'(i));
      os_cnt_d[i] = os_cnt_q[i];
      if (inc && !r_last_hs[i] && os_cnt_q[i] < OS_MAX)
        os_cnt_d[i] = os_cnt_q[i] + 1'b1;
      else if (r_last_hs[i] && !inc && os_cnt_q[i] != '0)
        os_cnt_d[i] = os_cnt_q[i] - 1'b1;
    end
  end

  assign dec_err_d = dec_err_q | (bus.slv_rvalid & ~r_idx_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= AR_IDLE;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      dec_err_q <= 1'b0;
      for (int i = 0; i < NUM_MST; i++)
        os_cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      dec_err_q <= dec_err_d;
      for (int i = 0; i < NUM_MST; i++)
        os_cnt_q[i] <= os_cnt_d[i];
    end
  end

  assign dec_err = dec_err_q;

endmodule
